// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: registered bitwise two-operand logic unit feeding a
// DEPTH-entry result FIFO, with valid/ready handshakes on both sides.
//
// Optional feature macro: LGU_STATS_EN
//   defined   -> adds the 32-bit op_count output (completed output transfers)
//   undefined -> op_count port and register are absent
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both high. valid, once raised, is held with stable
// payload until the transfer. in_ready and out_valid depend only on the
// registered occupancy count, so there is no combinational path from
// out_ready to in_ready (a full FIFO refuses input even while popping).
//
// state_dbg exposes the occupancy controller state:
//   0 = EMPTY, 1 = PARTIAL, 2 = FULL.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             c_zero,
  output logic [1:0]       state_dbg
`ifdef LGU_STATS_EN
  ,
  output logic [31:0]      op_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

`ifdef LGU_STATS_EN
  logic [31:0] op_count_q, op_count_d;
`endif

  // Bitwise operation selected by op; always exactly WIDTH bits.
  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = a & b;
      3'b001:  result = a | b;
      3'b010:  result = ~(a & b);
      3'b011:  result = ~(a | b);
      3'b100:  result = a ^ b;
      3'b101:  result = ~(a ^ b);
      3'b110:  result = ~a;
      default: result = a;
    endcase
  end

  // Handshake status from registered occupancy only; head data gated so an
  // empty FIFO always shows c=0 regardless of stale storage.
  always_comb begin
    in_ready  = (count_q != DEPTH_C);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    c         = out_valid ? mem_q[rd_ptr_q] : '0;
    c_zero    = (c == '0);
    state_dbg = state_q;
  end

  // Next storage, pointers and occupancy for this cycle's push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = result;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy controller next state; tracks count transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push && !pop) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && (count_q == DEPTH_C - CW'(1))) begin
          state_d = ST_FULL;
        end else if (pop && !push && (count_q == CW'(1))) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // FIFO storage, pointers, count and controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

`ifdef LGU_STATS_EN
  // Completed output transfer counter; wraps naturally at 32 bits.
  always_comb begin
    op_count_d = op_count_q;
    if (pop) op_count_d = op_count_q + 32'd1;
    op_count = op_count_q;
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed bench for logic_gate_pipe (WIDTH=8, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Define LGU_STATS_EN when compiling to include the op_count checks.
module tb_logic_gate_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             c_zero;
  logic [1:0]       state_dbg;
`ifdef LGU_STATS_EN
  logic [31:0]      op_count;
`endif

  logic_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .c_zero    (c_zero),
    .state_dbg (state_dbg)
`ifdef LGU_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int unsigned      pass_cnt  = 0;
  int unsigned      fail_cnt  = 0;
  int unsigned      check_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [2:0] ov);
    in_valid = v;
    a        = av;
    b        = bv;
    op       = ov;
  endtask

  logic [WIDTH-1:0] truth_exp [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03,
                                      8'h3C, 8'hC3, 8'h0F, 8'hF0};

  initial begin
    int unsigned pushed;
    logic        do_push;
    logic        do_pop;
    logic [1:0]  exp_state;

    drive(1'b0, '0, '0, 3'd0);
    out_ready = 1'b0;

    // ---- reset state ----
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_c_zero", c_zero, 1);
    check("rst_state", state_dbg, 0);
`ifdef LGU_STATS_EN
    check("rst_op_count", op_count, 0);
`endif
    #4 rst = 1'b0;
    step();

    // ---- truth sweep, a=F0 b=CC, out_ready=1 ----
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hF0, 8'hCC, 3'(i));
      step();
      check($sformatf("truth_valid_op%0d", i), out_valid, 1);
      check($sformatf("truth_c_op%0d", i), c, truth_exp[i]);
    end
    drive(1'b0, '0, '0, 3'd0);
    step();
    check("truth_drained", out_valid, 0);

    // ---- zero flag ----
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 8'h55, 3'b000);
    step();
    check("zero_and_c", c, 8'h00);
    check("zero_and_flag", c_zero, 1);
    check("zero_and_valid", out_valid, 1);
    out_ready = 1'b1;
    drive(1'b1, 8'hAA, 8'h55, 3'b100);
    step();
    check("zero_xor_c", c, 8'hFF);
    check("zero_xor_flag", c_zero, 0);
    drive(1'b0, '0, '0, 3'd0);
    step();
    check("zero_drained", out_valid, 0);

    // ---- fill and stall ----
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 8'h00, 3'b111);
      step();
      check($sformatf("fill_in_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
      check($sformatf("fill_head_%0d", i), c, 8'h01);
    end
    check("fill_state_full", state_dbg, 2);
    drive(1'b1, 8'h55, 8'h00, 3'b111);
    step();
    check("fill_5th_refused", in_ready, 0);
    check("fill_head_stable", c, 8'h01);
    drive(1'b0, '0, '0, 3'd0);
    out_ready = 1'b1;
    step();
    check("drain_in_ready_rise", in_ready, 1);
    check("drain_c_2", c, 8'h02);
    step();
    check("drain_c_3", c, 8'h03);
    step();
    check("drain_c_4", c, 8'h04);
    step();
    check("drain_empty", out_valid, 0);
    check("drain_state_empty", state_dbg, 0);

    // ---- streaming with alternating stalls, 10 pushes, pointer wrap ----
    exp_q.delete();
    pushed = 0;
    for (int cyc = 0; cyc < 60 && !(pushed == 10 && exp_q.size() == 0); cyc++) begin
      drive((pushed < 10), 8'(8'h10 + pushed), 8'h3C, 3'b100);
      out_ready = (cyc >= 2) && (cyc % 3 != 0);
      do_push = in_valid && (exp_q.size() != DEPTH);
      do_pop  = out_ready && (exp_q.size() != 0);
      step();
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(a ^ b);
        pushed++;
      end
      exp_state = (exp_q.size() == 0) ? 2'd0 : (exp_q.size() == DEPTH) ? 2'd2 : 2'd1;
      check($sformatf("stream_out_valid_c%0d", cyc), out_valid, (exp_q.size() != 0));
      check($sformatf("stream_in_ready_c%0d", cyc), in_ready, (exp_q.size() != DEPTH));
      check($sformatf("stream_state_c%0d", cyc), state_dbg, exp_state);
      if (exp_q.size() != 0) check($sformatf("stream_c_c%0d", cyc), c, exp_q[0]);
    end
    drive(1'b0, '0, '0, 3'd0);
    out_ready = 1'b0;
    check("stream_drained", out_valid, 0);
    check("stream_all_queued_data_seen", exp_q.size(), 0);

    // ---- async reset mid-stream ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h21 + i), 8'h00, 3'b111);
      step();
    end
    drive(1'b0, '0, '0, 3'd0);
    check("pre_rst_head", c, 8'h21);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_c", c, 0);
    check("arst_c_zero", c_zero, 1);
`ifdef LGU_STATS_EN
    check("arst_op_count", op_count, 0);
`endif
    #1 rst = 1'b0;
    step();
    out_ready = 1'b1;
    drive(1'b1, 8'h77, 8'h00, 3'b111);
    step();
    check("post_rst_c", c, 8'h77);
    check("post_rst_valid", out_valid, 1);
    drive(1'b0, '0, '0, 3'd0);
    step();
    check("post_rst_only_new", out_valid, 0);

`ifdef LGU_STATS_EN
    // ---- stats ----
    check("stats_after_one", op_count, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(i), 8'h00, 3'b111);
      step();
    end
    drive(1'b0, '0, '0, 3'd0);
    step();
    check("stats_plus_five", op_count, 6);
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_count_q;
    #1;
    check("stats_forced", op_count, 32'hFFFF_FFFF);
    step();
    drive(1'b1, 8'h01, 8'h00, 3'b111);
    step();
    drive(1'b0, '0, '0, 3'd0);
    step();
    check("stats_wrap", op_count, 0);
`endif

    // ---- report ----
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, registered successor to the standalone two-input NAND gate. Applies one of eight bitwise two-operand operations to WIDTH-bit operands per transaction and queues each result in a DEPTH-entry output FIFO. Valid/ready handshakes on both sides let it sit between a stimulus source and any stalling consumer in the gate-level datapath.

## Interface
- WIDTH, default 8: operand and result width in bits (1..64).
- DEPTH, default 4: result FIFO entries; power of two, 2..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  the source presents a, b and op.
- in_ready  output  1  the block accepts a transaction this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- op  input  3  operation select; see Operation.
- out_valid  output  1  the FIFO head holds a result.
- out_ready  input  1  the consumer takes the head result this cycle.
- c  output  WIDTH  head result.
- c_zero  output  1  head result is all zeros.
- op_count  output  32  number of completed output transfers; present only with LGU_STATS_EN.

## Operation
- op encoding (bitwise):
  - 000: AND, a&b
  - 001: OR, a|b
  - 010: NAND, ~(a&b)
  - 011: NOR, ~(a|b)
  - 100: XOR, a^b
  - 101: XNOR, ~(a^b)
  - 110: NOT, ~a, b ignored
  - 111: PASS, a, b ignored
- The result is always exactly WIDTH bits. There is no carry or extension.
- A push occurs when in_valid && in_ready. The computed result is written at wr_ptr.
- A pop occurs when out_valid && out_ready. rd_ptr advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count of log2(DEPTH)+1 bits tracks occupancy.
- in_ready = (count != DEPTH). When the FIFO is full, in_ready is low even if a pop happens in the same cycle; there is no pass-through on full.
- out_valid = (count != 0). c and c_zero are driven from the head entry and stay stable while out_valid && !out_ready.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push on empty: the entry becomes visible the next cycle. There is no same-cycle bypass.
- Pop on empty or push on full cannot occur, because the handshakes gate them.
- Controller states, derived from count:
  - EMPTY (count=0) goes to PARTIAL on a push alone.
  - PARTIAL goes to FULL on a push alone when count=DEPTH-1.
  - PARTIAL goes to EMPTY on a pop alone when count=1.
  - FULL goes to PARTIAL on a pop.
- Reset, asynchronous, mid-operation:
  - Pointers and count go to 0.
  - in_ready=1, out_valid=0, c=0, c_zero=1, op_count=0.
  - Any in-flight data is discarded.

## Timing
- Reset values: in_ready 1, out_valid 0, c 0, c_zero 1, op_count 0.
- Latency: a transaction accepted at edge N appears on c with out_valid=1 after edge N (cycle N+1), provided it is at the head.
- Throughput: one transaction per cycle in steady state when 0 < count < DEPTH.
- in_ready and out_valid are functions of registered count only. There is no combinational path from out_ready to in_ready.
- Deassertion of rst is synchronised externally. The first push may occur at the first edge after rst falls.

## Configuration
- LGU_STATS_EN defined:
  - op_count port exists. It is a 32-bit register that increments by 1 on every pop and wraps from 0xFFFFFFFF to 0.
  - Reset clears it.
- LGU_STATS_EN undefined:
  - op_count port and register are absent.
  - All other behaviour is identical.

## Test plan
- Truth sweep, WIDTH=8, out_ready=1: a=0xF0 and b=0xCC with op 0..7 give c = 0xC0, 0xFC, 0x3F, 0x03, 0x3C, 0xC3, 0x0F, 0xF0 in order, each one cycle after acceptance.
- Fill and stall, DEPTH=4, out_ready=0: push 4 transactions. in_ready drops after the 4th. A 5th in_valid is not accepted. Then assert out_ready: 4 results pop in FIFO order, and in_ready rises the cycle after the first pop.
- Simultaneous push/pop at count=2: count stays 2 and the output order is preserved across pointer wrap. Run 10 pushes through DEPTH=4 with alternating stalls.
- Zero flag: a=0xAA, b=0x55, op=000 gives c=0x00 and c_zero=1. op=100 gives c=0xFF and c_zero=0.
- Async reset mid-stream: with 3 entries queued, pulse rst between edges. out_valid goes 0 and in_ready goes 1 immediately, c=0, and op_count=0 (LGU_STATS_EN). A fresh push after reset returns only the new result.
- Stats, LGU_STATS_EN: 5 pops give op_count=5. Force 0xFFFFFFFF, then 1 pop gives 0. With the macro undefined, the bench compiles without op_count.
